// File: rtl/apb_ctrl_pkg.sv
// rtl/apb_ctrl_pkg.sv - shared types and packed-vector helpers for the APB master arbiter
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_mst_state_e;

    // Upper bounds for the generic slice helper; callers zero-extend into the
    // wide argument and truncate the result back to their own field width.
    localparam int SLICE_MAX_W   = 64;
    localparam int SLICE_MAX_VEC = 1024;

    // Extract field idx of width w from a packed vector of equal-width fields.
    function automatic logic [SLICE_MAX_W-1:0] vec_slice(
        input logic [SLICE_MAX_VEC-1:0] vec,
        input int unsigned              idx,
        input int unsigned              w
    );
        logic [SLICE_MAX_W-1:0] mask;
        if (w >= SLICE_MAX_W)
            mask = '1;
        else
            mask = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
        return SLICE_MAX_W'(vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a given pointer
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic found;

    // Two passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(pointer))) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < int'(pointer))) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin shared APB master running one SETUP/ACCESS transfer per grant
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_mst_state_e state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      cur_idx;
    logic [NUM_REQ-1:0] cur_gnt;
    logic [CW-1:0]      wait_cnt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_idx     <= '0;
            cur_gnt     <= '0;
            wait_cnt    <= '0;
            ack         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        cur_idx <= arb_idx;
                        cur_gnt <= arb_gnt;
                        paddr   <= ADDR_WIDTH'(vec_slice(SLICE_MAX_VEC'(req_addr),
                                                         32'(arb_idx), ADDR_WIDTH));
                        pwdata  <= DATA_WIDTH'(vec_slice(SLICE_MAX_VEC'(req_wdata),
                                                         32'(arb_idx), DATA_WIDTH));
                        pwrite  <= |(req_write & arb_gnt);
                        psel    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave always wins over a timeout in the same cycle.
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        ack         <= cur_gnt;
                        state       <= DONE;
                    end else if ((TIMEOUT_CYCLES > 0) &&
                                 (wait_cnt == CW'(TIMEOUT_CYCLES - 1))) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        ack         <= cur_gnt;
                        state       <= DONE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    ack         <= '0;
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                    busy        <= 1'b0;
                    rr_ptr      <= (cur_idx == IW'(NUM_REQ - 1)) ? '0 : cur_idx + IW'(1);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0] ack;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int vectors;
    int miscompares;

    apb_master_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ack         (ack),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        cyc();
        cyc();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        cyc();

        // Single read from requester 0; pready already high during SETUP.
        req = 2'b01; req_write = 2'b00; req_addr[15:0] = 16'h0010;
        cyc();
        chk("t1_psel", psel, 1);
        chk("t1_penable_setup", penable, 0);
        chk("t1_paddr", paddr, 32'h10);
        chk("t1_pwrite", pwrite, 0);
        chk("t1_busy", busy, 1);
        prdata = 32'hA5A5_0001; pready = 1'b1;
        cyc();
        chk("t1_penable", penable, 1);
        chk("t1_ack_early", ack, 0);
        cyc();
        chk("t1_ack", ack, 2'b01);
        chk("t1_rdata", rsp_rdata, 32'hA5A5_0001);
        chk("t1_err", rsp_err, 0);
        chk("t1_tmo", rsp_timeout, 0);
        chk("t1_psel_off", psel, 0);
        req = 2'b00; pready = 1'b0;
        cyc();
        chk("t1_ack_clear", ack, 0);
        chk("t1_rdata_clear", rsp_rdata, 0);
        chk("t1_busy_clear", busy, 0);

        // Single read from requester 1 moves the pointer back to 0.
        req = 2'b10; req_addr[31:16] = 16'h0030;
        cyc();
        chk("t1b_paddr", paddr, 32'h30);
        prdata = 32'h5A5A_0002; pready = 1'b1;
        cyc();
        cyc();
        chk("t1b_ack", ack, 2'b10);
        chk("t1b_rdata", rsp_rdata, 32'h5A5A_0002);
        req = 2'b00;
        cyc();

        // Contention: both writes held, zero-wait slave, grants must alternate 0,1,0,1.
        req = 2'b11; req_write = 2'b11;
        req_addr  = {16'h0024, 16'h0020};
        req_wdata = {32'h2222_0001, 32'h1111_0000};
        prdata = 32'hDEAD_BEEF; pready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            cyc();
            chk("t2_psel", psel, 1);
            chk("t2_pwrite", pwrite, 1);
            chk("t2_paddr", paddr, (g % 2 == 0) ? 32'h20 : 32'h24);
            chk("t2_pwdata", pwdata, (g % 2 == 0) ? 32'h1111_0000 : 32'h2222_0001);
            cyc();
            chk("t2_penable", penable, 1);
            cyc();
            chk("t2_ack", ack, (g % 2 == 0) ? 32'b01 : 32'b10);
            chk("t2_wr_rdata", rsp_rdata, 0);
            chk("t2_psel_done", psel, 0);
            cyc();
            chk("t2_psel_gap", psel, 0);
            chk("t2_ack_gap", ack, 0);
            if (g == 3) req = 2'b00;
        end
        cyc();

        // Wait states: pready only in the 4th ACCESS cycle, with pslverr.
        req = 2'b01; req_write = 2'b00; req_addr[15:0] = 16'h0040;
        prdata = 32'h1234_5678; pready = 1'b0; pslverr = 1'b1;
        cyc();
        chk("t3_psel", psel, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t3_penable", penable, 1);
            chk("t3_paddr_stable", paddr, 32'h40);
            chk("t3_pwrite_stable", pwrite, 0);
            chk("t3_ack_wait", ack, 0);
            if (k == 3) pready = 1'b1;
        end
        cyc();
        chk("t3_ack", ack, 2'b01);
        chk("t3_err", rsp_err, 1);
        chk("t3_tmo", rsp_timeout, 0);
        chk("t3_rdata", rsp_rdata, 32'h1234_5678);
        chk("t3_penable_off", penable, 0);
        req = 2'b00; pready = 1'b0; pslverr = 1'b0;
        cyc();
        chk("t3_ack_clear", ack, 0);

        // Reset in ACCESS of requester 1 while the pointer sits at 1.
        req = 2'b10; req_addr[31:16] = 16'h0050;
        cyc();
        cyc();
        chk("t5_in_access", penable, 1);
        rst_n = 1'b0;
        cyc();
        chk("t5_psel", psel, 0);
        chk("t5_penable", penable, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ack", ack, 0);
        chk("t5_paddr", paddr, 0);
        rst_n = 1'b1; req = 2'b00;
        cyc();
        chk("t5_no_ack", ack, 0);
        chk("t5_idle_psel", psel, 0);
        // Pointer back at 0: with both requesting, requester 0 wins.
        req = 2'b11; req_write = 2'b00;
        req_addr = {16'h0074, 16'h0070};
        prdata = 32'hCAFE_0070; pready = 1'b1;
        cyc();
        chk("t5_grant_paddr", paddr, 32'h70);
        cyc();
        cyc();
        chk("t5_grant_ack", ack, 2'b01);
        chk("t5_rdata", rsp_rdata, 32'hCAFE_0070);
        req = 2'b00; pready = 1'b0;
        cyc();

        // Timeout on requester 1: slave never ready.
        req = 2'b10; req_addr[31:16] = 16'h0050; prdata = 32'hFFFF_FFFF;
        cyc();
        chk("t4_psel", psel, 1);
        chk("t4_paddr", paddr, 32'h50);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4_penable", penable, 1);
            chk("t4_ack_wait", ack, 0);
        end
        cyc();
        chk("t4_ack", ack, 2'b10);
        chk("t4_err", rsp_err, 1);
        chk("t4_tmo", rsp_timeout, 1);
        chk("t4_rdata", rsp_rdata, 0);
        chk("t4_psel_off", psel, 0);
        chk("t4_penable_off", penable, 0);
        req = 2'b00;
        cyc();
        chk("t4_ack_clear", ack, 0);
        chk("t4_tmo_clear", rsp_timeout, 0);
        chk("t4_busy_clear", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
